// File: rtl/riptide_pkg.sv
// Shared RIPTIDE-II instruction-set constants.
// Used by both the instruction encoder (loader/debug path) and the decode unit,
// so that opcode numbering and field positions are defined in exactly one place.
package riptide_pkg;

    // 3-bit major opcodes
    localparam logic [2:0] OP_MOVE = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_XEC  = 3'd4;
    localparam logic [2:0] OP_NZT  = 3'd5;
    localparam logic [2:0] OP_XMIT = 3'd6;
    localparam logic [2:0] OP_JMP  = 3'd7;

    // Bit of the 5-bit S/D field that selects the IV bus instead of a register
    localparam int IV_BIT = 4;

    // All-zero instruction word (MOVE R0 -> R0)
    localparam logic [15:0] NOP_WORD = 16'h0000;

endpackage

// File: rtl/enc_fifo.sv
// Small synchronous queue of encoded instruction words.
// Ports:
//   clk, RST      - clock, synchronous active-high reset (empties the queue)
//   push, din     - enqueue din (ignored when full)
//   pop           - dequeue head (ignored when empty)
//   dout          - current head word
//   count, empty  - occupancy
module enc_fifo
    import riptide_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic                       push,
    input  logic [15:0]                din,
    input  logic                       pop,
    output logic [15:0]                dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [15:0]   mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Protect against overflow/underflow even if the caller misbehaves
    assign push_ok_s = push & (count_r != DEPTH_C);
    assign pop_ok_s  = pop & (count_r != {CW{1'b0}});

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (!RST && push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (RST) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = (count_r == {CW{1'b0}}) ? NOP_WORD : mem_r[rd_ptr_r];
    assign count = count_r;
    assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/instr_encoder.sv
// RIPTIDE-II instruction encoder: packs decoded fields into 16-bit words and
// streams them into program memory at an auto-incrementing address.
// Ports:
//   clk, RST                 - clock, synchronous active-high reset
//   in_valid/in_ready        - field handshake
//   op, src, rl, dst, imm    - instruction fields
//   addr_load, addr_value    - reload the write address counter
//   prog_addr/data/wren/wait - stallable program memory write port
//   err_pulse, err_count     - reject indication and saturating reject count
//   wrapped                  - one-cycle pulse when the address wraps to 0
module instr_encoder
    import riptide_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [4:0]        src,
    input  logic [2:0]        rl,
    input  logic [4:0]        dst,
    input  logic [12:0]       imm,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_value,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [15:0]       prog_data,
    output logic              prog_wren,
    input  logic              prog_wait,
    output logic              err_pulse,
    output logic [7:0]        err_count,
    output logic              wrapped
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]     DEPTH_C  = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [15:0]       word_s;
    logic              enc_err_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic [15:0]       head_s;
    logic [CW-1:0]     count_s;
    logic              empty_s;
    logic [ADDR_W-1:0] addr_r;
    logic              wrapped_r;
    logic              err_pulse_r;
    logic [7:0]        err_count_r;

    // Field packing and over-range immediate detection
    always_comb begin
        word_s    = NOP_WORD;
        enc_err_s = 1'b0;
        case (op)
            OP_MOVE, OP_ADD, OP_AND, OP_XOR: begin
                word_s    = {op, src, rl, dst};
                enc_err_s = 1'b0;
            end
            OP_XEC, OP_NZT: begin
                // IV-bus source carries a rotate/length field, leaving 5 immediate bits
                if (src[IV_BIT]) begin
                    word_s    = {op, src, rl, imm[4:0]};
                    enc_err_s = |imm[12:5];
                end else begin
                    word_s    = {op, src, imm[7:0]};
                    enc_err_s = |imm[12:8];
                end
            end
            OP_XMIT: begin
                if (dst[IV_BIT]) begin
                    word_s    = {op, dst, rl, imm[4:0]};
                    enc_err_s = |imm[12:5];
                end else begin
                    word_s    = {op, dst, imm[7:0]};
                    enc_err_s = |imm[12:8];
                end
            end
            OP_JMP: begin
                word_s    = {op, imm};
                enc_err_s = 1'b0;
            end
            default: begin
                word_s    = NOP_WORD;
                enc_err_s = 1'b0;
            end
        endcase
    end

    assign in_ready = ~RST & (count_s < DEPTH_C);
    assign accept_s = in_valid & in_ready;
    assign push_s   = accept_s & ~enc_err_s;
    assign pop_s    = prog_wren & ~prog_wait;

    enc_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .RST   (RST),
        .push  (push_s),
        .din   (word_s),
        .pop   (pop_s),
        .dout  (head_s),
        .count (count_s),
        .empty (empty_s)
    );

    // Write address counter; a load overrides the post-write increment
    always_ff @(posedge clk) begin
        if (RST) begin
            addr_r    <= {ADDR_W{1'b0}};
            wrapped_r <= 1'b0;
        end else begin
            if (addr_load) begin
                addr_r <= addr_value;
            end else if (pop_s) begin
                addr_r <= addr_r + ADDR_ONE;
            end
            wrapped_r <= pop_s & ~addr_load & (addr_r == ADDR_MAX);
        end
    end

    // Reject pulse and saturating reject counter
    always_ff @(posedge clk) begin
        if (RST) begin
            err_pulse_r <= 1'b0;
            err_count_r <= 8'd0;
        end else begin
            err_pulse_r <= accept_s & enc_err_s;
            if (accept_s && enc_err_s && (err_count_r != 8'hFF)) begin
                err_count_r <= err_count_r + 8'd1;
            end
        end
    end

    // Outputs are forced quiet for the whole time RST is held, not only after the edge
    assign prog_wren = ~RST & ~empty_s;
    assign prog_data = RST ? NOP_WORD : head_s;
    assign prog_addr = RST ? {ADDR_W{1'b0}} : addr_r;
    assign err_pulse = ~RST & err_pulse_r;
    assign err_count = RST ? 8'd0 : err_count_r;
    assign wrapped   = ~RST & wrapped_r;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    localparam int ADDR_W = 13;
    localparam int DEPTH  = 2;
    localparam int AMOD   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              RST = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        op = 3'd0;
    logic [4:0]        src = 5'd0;
    logic [2:0]        rl = 3'd0;
    logic [4:0]        dst = 5'd0;
    logic [12:0]       imm = 13'd0;
    logic              addr_load = 1'b0;
    logic [ADDR_W-1:0] addr_value = '0;
    logic [ADDR_W-1:0] prog_addr;
    logic [15:0]       prog_data;
    logic              prog_wren;
    logic              prog_wait = 1'b0;
    logic              err_pulse;
    logic [7:0]        err_count;
    logic              wrapped;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .RST        (RST),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .src        (src),
        .rl         (rl),
        .dst        (dst),
        .imm        (imm),
        .addr_load  (addr_load),
        .addr_value (addr_value),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .prog_wren  (prog_wren),
        .prog_wait  (prog_wait),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .wrapped    (wrapped)
    );

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference encoding from the field-layout table, using plain arithmetic
    function automatic void m_encode(input int o, input int s, input int r, input int d,
                                     input int im, output int w, output bit e);
        w = 0;
        e = 1'b0;
        if (o <= 3) begin
            w = o * 8192 + s * 256 + r * 32 + d;
        end else if (o == 7) begin
            w = o * 8192 + im;
        end else begin
            int f;
            f = (o == 6) ? d : s;
            if (f >= 16) begin
                w = o * 8192 + f * 256 + r * 32 + (im % 32);
                e = (im >= 32);
            end else begin
                w = o * 8192 + f * 256 + (im % 256);
                e = (im >= 256);
            end
        end
    endfunction

    // Model state: what has been accepted but not yet written, plus counters
    logic [15:0] mq[$];
    int m_addr = 0;
    int m_err_cnt = 0;
    bit m_err_pulse = 1'b0;
    bit m_wrapped = 1'b0;

    always @(negedge clk) begin
        int w;
        bit e;
        bit done;
        bit acc;
        if (RST) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_prog_wren", prog_wren, 0);
            check("rst_prog_addr", prog_addr, 0);
            check("rst_prog_data", prog_data, 0);
            check("rst_err_pulse", err_pulse, 0);
            check("rst_err_count", err_count, 0);
            check("rst_wrapped", wrapped, 0);
        end else begin
            check("in_ready", in_ready, (mq.size() < DEPTH) ? 1 : 0);
            check("prog_wren", prog_wren, (mq.size() > 0) ? 1 : 0);
            if (mq.size() > 0) check("prog_data", prog_data, mq[0]);
            check("prog_addr", prog_addr, m_addr);
            check("err_pulse", err_pulse, m_err_pulse);
            check("err_count", err_count, m_err_cnt);
            check("wrapped", wrapped, m_wrapped);
        end
        // advance the model across the coming rising edge
        if (RST) begin
            mq.delete();
            m_addr = 0;
            m_err_cnt = 0;
            m_err_pulse = 1'b0;
            m_wrapped = 1'b0;
        end else begin
            done = (mq.size() > 0) && !prog_wait;
            acc  = in_valid && (mq.size() < DEPTH);
            m_encode(op, src, rl, dst, imm, w, e);
            m_wrapped = done && !addr_load && (m_addr == AMOD - 1);
            if (done) void'(mq.pop_front());
            if (acc && !e) mq.push_back(w[15:0]);
            if (addr_load) m_addr = addr_value;
            else if (done) m_addr = (m_addr + 1) % AMOD;
            m_err_pulse = acc && e;
            if (acc && e && m_err_cnt < 255) m_err_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int o, input int s, input int r, input int d, input int im);
        op = 3'(o); src = 5'(s); rl = 3'(r); dst = 5'(d); imm = 13'(im);
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (in_ready) begin
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        check("offer_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            if (!prog_wren) return;
            tick();
        end
        check("drain_timeout", 0, 1);
    endtask

    initial begin
        int w;
        bit e;
        // pin the reference encoder with hand-computed words
        m_encode(7, 0, 0, 0, 'h1ABC, w, e);
        check("model_jmp", w, 'hFABC);
        m_encode(5, 'h07, 0, 0, 'h0042, w, e);
        check("model_call", w, 'hA742);
        m_encode(6, 0, 3, 'h1B, 'h0015, w, e);
        check("model_xmit", w, 'hDB75);
        m_encode(6, 0, 3, 'h1B, 'h0025, w, e);
        check("model_xmit_err", e, 1);

        repeat (3) tick();
        RST = 1'b0;
        tick();

        // first word: all-zero MOVE at address 0
        offer(0, 0, 0, 0, 0);
        check("first_wren", prog_wren, 1);
        check("first_data", prog_data, 'h0000);
        check("first_addr", prog_addr, 0);
        tick();
        check("first_addr_after", prog_addr, 1);
        check("first_wren_after", prog_wren, 0);

        // JMP then CALL
        offer(7, 0, 0, 0, 'h1ABC);
        check("jmp_data", prog_data, 'hFABC);
        check("jmp_addr", prog_addr, 1);
        offer(5, 'h07, 0, 0, 'h0042);
        check("call_data", prog_data, 'hA742);
        check("call_addr", prog_addr, 2);
        drain();

        // XMIT to IV bus, then over-range immediate
        offer(6, 0, 3, 'h1B, 'h0015);
        check("xmit_data", prog_data, 'hDB75);
        drain();
        offer(6, 0, 3, 'h1B, 'h0025);
        check("rej_pulse", err_pulse, 1);
        check("rej_count", err_count, 1);
        check("rej_wren", prog_wren, 0);
        tick();
        check("rej_pulse_gone", err_pulse, 0);

        // back-pressure: stall memory, fill the queue
        prog_wait = 1'b1;
        offer(0, 1, 2, 3, 0);
        offer(1, 4, 5, 6, 0);
        op = 3'd2; src = 5'd9; rl = 3'd1; dst = 5'd2; imm = 13'd0;
        in_valid = 1'b1;
        check("stall_not_ready", in_ready, 0);
        repeat (3) tick();
        check("stall_addr", prog_addr, 4);
        check("stall_data", prog_data, 'h0143);
        prog_wait = 1'b0;
        offer(2, 9, 1, 2, 0);
        drain();
        check("stall_addr_end", prog_addr, 7);

        // wrap across the top of the address space
        addr_load = 1'b1; addr_value = 13'h1FFF;
        tick();
        addr_load = 1'b0;
        check("load_addr", prog_addr, 'h1FFF);
        offer(3, 1, 1, 1, 0);
        offer(2, 2, 2, 2, 0);
        drain();
        check("wrap_addr_end", prog_addr, 1);

        // load coinciding with a completing write
        offer(1, 2, 3, 4, 0);
        addr_load = 1'b1; addr_value = 13'h0100;
        tick();
        addr_load = 1'b0;
        check("load_wins_addr", prog_addr, 'h100);
        check("load_wins_popped", prog_wren, 0);

        // error counter saturation
        op = 3'd4; src = 5'd0; imm = 13'h1F00; in_valid = 1'b1;
        repeat (300) tick();
        in_valid = 1'b0;
        tick();
        check("sat_count", err_count, 255);
        check("sat_no_push", prog_wren, 0);

        // reset while stalled with a full queue
        prog_wait = 1'b1;
        offer(0, 3, 3, 3, 0);
        offer(0, 4, 4, 4, 0);
        check("pre_rst_wren", prog_wren, 1);
        RST = 1'b1;
        tick();
        check("rst_mid_wren", prog_wren, 0);
        check("rst_mid_addr", prog_addr, 0);
        check("rst_mid_errcnt", err_count, 0);
        RST = 1'b0;
        prog_wait = 1'b0;
        tick();
        check("post_rst_empty", prog_wren, 0);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            op        = 3'($urandom_range(0, 7));
            src       = 5'($urandom_range(0, 31));
            rl        = 3'($urandom_range(0, 7));
            dst       = 5'($urandom_range(0, 31));
            imm       = ($urandom_range(0, 3) == 0) ? 13'($urandom_range(0, 8191))
                                                    : 13'($urandom_range(0, 31));
            prog_wait = ($urandom_range(0, 3) == 0);
            addr_load = ($urandom_range(0, 63) == 0);
            addr_value = ($urandom_range(0, 1) == 1) ? 13'($urandom_range(8189, 8191))
                                                     : 13'($urandom_range(0, 8191));
            RST       = ($urandom_range(0, 499) == 0);
            tick();
        end
        RST = 1'b0;
        in_valid = 1'b0;
        addr_load = 1'b0;
        prog_wait = 1'b0;
        tick();
        drain();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encodes decoded instruction fields (opcode, source, R/L, destination, immediate) into 16-bit RIPTIDE-II instruction words. This is the inverse of the decode unit.
- Writes the encoded words sequentially into program memory through a stallable write port.
- Used by the debug/loader path to assemble and patch program RAM at runtime.
- Contains an input valid/ready handshake, a small word queue, an address counter, and error accounting.

Parameters:
- ADDR_W, 13, program memory address width. The address wraps modulo 2^ADDR_W.
- DEPTH, 2, number of entries in the encoded-word queue. Must be a power of two and at least 2.

Ports:
- clk  in  1  system clock.
- RST  in  1  reset, synchronous, active-high.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  block can accept fields this cycle.
- op  in  3  opcode: 0 move, 1 add, 2 and, 3 xor, 4 xec, 5 nzt, 6 xmit, 7 jmp.
- src  in  5  S field; bit 4 set means IV-bus source.
- rl  in  3  R/L field.
- dst  in  5  D field; bit 4 set means IV-bus destination.
- imm  in  13  immediate or jump address.
- addr_load  in  1  load the write address counter.
- addr_value  in  ADDR_W  address to load.
- prog_addr  out  ADDR_W  program memory write address.
- prog_data  out  16  encoded word.
- prog_wren  out  1  write request.
- prog_wait  in  1  memory stall; while high, the write does not complete.
- err_pulse  out  1  one-cycle pulse on a rejected instruction.
- err_count  out  8  saturating count of rejects.
- wrapped  out  1  one-cycle pulse when the address counter wraps to 0.

Behaviour:
- Reset: RST is synchronous and active-high. While RST is high, all outputs are 0 (in_ready=0), the queue is emptied, and the address counter is 0.

Encoding (combinational on the inputs; imm above the field width must be zero):
- op 0-3: {op, src, rl, dst}. imm is ignored and never causes an error.
- op 4/5, src[4]=0: {op, src, imm[7:0]}. Error if imm[12:8]≠0.
- op 4/5, src[4]=1: {op, src, rl, imm[4:0]}. Error if imm[12:5]≠0.
- op 6, dst[4]=0: {op, dst, imm[7:0]}. Error if imm[12:8]≠0.
- op 6, dst[4]=1: {op, dst, rl, imm[4:0]}. Error if imm[12:5]≠0.
- op 7: {op, imm[12:0]}.
- CALL and RET are plain op 5 encodings with src=5'h07 and src=5'h0F; the encoder gives them no special case.

Handshake and queue:
- in_ready = ~RST & (queue count < DEPTH).
- A transfer occurs when in_valid & in_ready at a clock edge.
- Valid transfer: push the word.
- Error transfer: consume the fields without pushing; err_pulse=1 in the next cycle; err_count increments and saturates at 255.
- Push and pop in the same cycle are both allowed; the count is unchanged.
- There is no combinational bypass. The earliest a word appears on prog_data is the cycle after acceptance.

Memory write:
- prog_wren = queue non-empty. prog_data = queue head. prog_addr = counter.
- A write completes at an edge where prog_wren & ~prog_wait. On completion: pop the head and increment the counter.
- prog_addr, prog_data and prog_wren hold stable while prog_wait is high.

Address counter:
- addr_load has priority over increment at the same edge. A completing write in that cycle still pops, but the counter takes addr_value.
- Entries still queued are written from addr_value onward.
- Increment from 2^ADDR_W-1 goes to 0 and asserts wrapped for one cycle (the cycle after the edge).

Reset mid-operation: pending queue entries are discarded and the counter is 0. err_count clears.

Decomposition:
- Shared package riptide_pkg holds the opcode constants (OP_MOVE…OP_JMP), the IV-bus select bit index (4), and the NOP word 16'h0000. The decode unit reuses these constants.
- One sub-module, enc_fifo: synchronous DEPTH×16 queue with push/pop/count, RST-cleared.
- Encoding and error checks live in the top level.

Test Plan:
- Reset, then op=0 src=0 rl=0 dst=0 → prog_wren rises next cycle; prog_data=16'h0000 at prog_addr=0; write completes; prog_addr=1.
- op=7 imm=13'h1ABC → prog_data=16'hFABC. Then op=5 src=5'h07 imm=13'h0042 (CALL) → 16'hA742 at the next address.
- op=6 dst=5'h1B rl=3 imm=13'h0015 → 16'hDB75. Same with imm=13'h0025 → nothing written; err_pulse for one cycle; err_count=1.
- Hold prog_wait=1 and offer 3 instructions back-to-back with DEPTH=2 → in_ready drops after 2 accepts; outputs stay stable. Release prog_wait → words are written in order at consecutive addresses, then the third is accepted.
- addr_load with addr_value=13'h1FFF, then 2 writes → addresses 13'h1FFF then 13'h0000; wrapped pulses once. Repeat with addr_load coinciding with a completing write → loaded value wins.
- 300 error transfers → err_count=255, no wrap. Assert RST mid-stall with 2 queued → prog_wren=0 the next cycle; queue empty; addr=0; err_count=0.
